edge_event_unit: RTL

Multi-channel, parametrised edge/event detector for asynchronous pad or peripheral inputs (SPI/PWM control lines, buttons).

---
 rtl/edge_event_unit.sv | 83 ++++++++
 1 files changed

// File: rtl/edge_event_unit.sv
// Multi-channel edge/event detector: synchroniser, glitch filter, mode-qualified
// edge pulse, sticky flag and saturating counter per channel.
module edge_event_unit #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4,
  parameter int CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       sig_in,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [FILT_W-1:0]         filt_len,
  input  logic [CHANNELS-1:0]       flag_clr,
  input  logic                      cnt_clr,
  output logic [CHANNELS-1:0]       level,
  output logic [CHANNELS-1:0]       edge_pulse,
  output logic [CHANNELS-1:0]       event_flag,
  output logic [CNT_W*CHANNELS-1:0] event_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic [FILT_W-1:0]      fcnt_p1;
    logic                   level_p1;
    logic                   pend_p2;
    logic                   pulse_p3;
    logic                   flag_p4;
    logic [CNT_W-1:0]       cnt_p4;
    logic                   sync_bit;
    logic                   change;
    logic                   qualified;

    assign sync_bit  = sync_p0[SYNC_STAGES-1];
    assign change    = (sync_bit != level_p1) && (fcnt_p1 >= filt_len);
    // The mode sampled here is the one present at the edge where level moves.
    assign qualified = sync_bit ? mode[2*ch] : mode[2*ch+1];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_p0  <= '0;
        fcnt_p1  <= '0;
        level_p1 <= 1'b0;
        pend_p2  <= 1'b0;
        pulse_p3 <= 1'b0;
        flag_p4  <= 1'b0;
        cnt_p4   <= '0;
      end else begin
        // p0: synchroniser shift chain
        sync_p0 <= (sync_p0 << 1) | SYNC_STAGES'(sig_in[ch]);

        // p1: glitch filter, >= lets a shortened filt_len release immediately
        if (sync_bit == level_p1) begin
          fcnt_p1 <= '0;
        end else if (change) begin
          level_p1 <= sync_bit;
          fcnt_p1  <= '0;
        end else begin
          fcnt_p1 <= fcnt_p1 + FILT_W'(1);
        end

        // p2/p3: qualified transition, then the registered one-cycle strobe
        pend_p2  <= change && qualified;
        pulse_p3 <= pend_p2;

        // p4: sticky flag (set beats clear) and counter (a pulse survives cnt_clr)
        flag_p4 <= pulse_p3 | (flag_p4 & ~flag_clr[ch]);
        if (cnt_clr)       cnt_p4 <= pulse_p3 ? CNT_W'(1) : '0;
        else if (pulse_p3) cnt_p4 <= sat_inc(cnt_p4);
      end
    end

    assign level[ch]                       = level_p1;
    assign edge_pulse[ch]                  = pulse_p3;
    assign event_flag[ch]                  = flag_p4;
    assign event_cnt[CNT_W*ch +: CNT_W]    = cnt_p4;
  end

endmodule
